// File: rtl/iq_demod_pkg.sv
// Shared definitions for the IQ readout demodulator: FSM state encoding,
// default widths, LUT geometry and the accumulator overflow helpers.
// Optional build macro: IQ_DEMOD_SATURATE_EN (clamp accumulators instead of wrapping).
package iq_demod_pkg;

    localparam int AdcWDefault  = 14;
    localparam int CoefWDefault = 12;
    localparam int LutDepth     = 16;
    localparam int PhaseW       = $clog2(LutDepth);
    localparam int AccW         = 32;
    localparam int CntW         = 16;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StIntegrate,
        StDone
    } state_e;

    // The sum is one bit wider than the accumulator; the top two bits
    // disagree exactly when the signed 32-bit result does not fit.
    function automatic logic acc_ovf(input logic signed [AccW:0] sum);
        return sum[AccW] ^ sum[AccW-1];
    endfunction

    // Reduce a widened sum back to accumulator width.
    function automatic logic signed [AccW-1:0] acc_limit(input logic signed [AccW:0] sum);
        logic signed [AccW-1:0] res;
        res = sum[AccW-1:0];
`ifdef IQ_DEMOD_SATURATE_EN
        if (acc_ovf(sum)) begin
            // Sign of the true sum picks the rail.
            res = sum[AccW] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/iq_demod_lut.sv
// Combinational 16-entry cosine/sine table for the demodulator NCO.
// Entries are round(2047 * cos(2*pi*k/16)); sine reuses the same table
// shifted by a quarter turn, since sin(x) = cos(x - pi/2).
module iq_demod_lut
    import iq_demod_pkg::*;
#(
    parameter int COEF_W = CoefWDefault
) (
    input  logic        [PhaseW-1:0] phase,
    output logic signed [COEF_W-1:0] cos_val,
    output logic signed [COEF_W-1:0] sin_val
);

    localparam int CosTab [LutDepth] = '{
         2047,  1891,  1447,   783,
            0,  -783, -1447, -1891,
        -2047, -1891, -1447,  -783,
            0,   783,  1447,  1891
    };

    // A quarter turn is LutDepth/4 table steps.
    localparam logic [PhaseW-1:0] QuarterTurn = PhaseW'(LutDepth / 4);

    logic [PhaseW-1:0] sin_idx;

    assign sin_idx = phase - QuarterTurn;

    // Table lookup, truncated to the coefficient width.
    always_comb begin
        cos_val = COEF_W'(CosTab[phase]);
        sin_val = COEF_W'(CosTab[sin_idx]);
    end

endmodule

// File: rtl/iq_demod.sv
// IQ readout demodulator: on trigger, skips delay_len valid ADC samples,
// then mixes window_len samples with a 16-step cos/sin NCO and integrates
// I and Q into 32-bit accumulators. One iq_valid strobe per measurement.
// Optional build macro: IQ_DEMOD_SATURATE_EN (clamp accumulators instead of wrapping).
module iq_demod
    import iq_demod_pkg::*;
#(
    parameter int ADC_W  = AdcWDefault,
    parameter int COEF_W = CoefWDefault
) (
    input  logic                    clk100,
    input  logic                    rst,
    input  logic                    trigger,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic                    adc_valid,
    input  logic        [CntW-1:0]  delay_len,
    input  logic        [CntW-1:0]  window_len,
    input  logic        [PhaseW-1:0] pinc,
    output logic signed [AccW-1:0]  i_val,
    output logic signed [AccW-1:0]  q_val,
    output logic                    iq_valid,
    output logic                    busy,
    output logic                    overflow
);

    localparam int ProdW = ADC_W + COEF_W;

    state_e                    state;
    logic        [CntW-1:0]    dly_q;
    logic        [CntW-1:0]    win_q;
    logic        [PhaseW-1:0]  pinc_q;
    logic        [CntW-1:0]    cnt_q;
    logic        [PhaseW-1:0]  phase_q;
    logic signed [AccW-1:0]    acc_i_q;
    logic signed [AccW-1:0]    acc_q_q;
    logic                      ovf_q;

    logic signed [COEF_W-1:0]  cos_val;
    logic signed [COEF_W-1:0]  sin_val;
    logic signed [ProdW-1:0]   prod_i;
    logic signed [ProdW-1:0]   prod_q;
    logic signed [AccW:0]      sum_i;
    logic signed [AccW:0]      sum_q;
    logic signed [AccW-1:0]    acc_i_d;
    logic signed [AccW-1:0]    acc_q_d;
    logic                      ovf_d;
    logic                      last_dly;
    logic                      last_win;

    iq_demod_lut #(
        .COEF_W (COEF_W)
    ) u_lut (
        .phase   (phase_q),
        .cos_val (cos_val),
        .sin_val (sin_val)
    );

    // Mixer and widened accumulate; overflow is judged on the 33-bit sum.
    always_comb begin
        prod_i  = ProdW'(adc_data) * ProdW'(cos_val);
        prod_q  = ProdW'(adc_data) * ProdW'(sin_val);
        sum_i   = (AccW + 1)'(acc_i_q) + (AccW + 1)'(prod_i);
        sum_q   = (AccW + 1)'(acc_q_q) + (AccW + 1)'(prod_q);
        acc_i_d = acc_limit(sum_i);
        acc_q_d = acc_limit(sum_q);
        ovf_d   = ovf_q | acc_ovf(sum_i) | acc_ovf(sum_q);
    end

    // Sample-count terminal conditions for the delay and integration windows.
    always_comb begin
        last_dly = (cnt_q == dly_q - CntW'(1));
        last_win = (cnt_q == win_q - CntW'(1));
    end

    // Measurement FSM with registered outputs; results are loaded on the
    // edge that enters DONE so iq_valid is high for the whole DONE cycle.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state    <= StIdle;
            dly_q    <= '0;
            win_q    <= '0;
            pinc_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            ovf_q    <= 1'b0;
            i_val    <= '0;
            q_val    <= '0;
            iq_valid <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            iq_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (trigger) begin
                        dly_q   <= delay_len;
                        win_q   <= window_len;
                        pinc_q  <= pinc;
                        cnt_q   <= '0;
                        phase_q <= '0;
                        acc_i_q <= '0;
                        acc_q_q <= '0;
                        ovf_q   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= StDelay;
                    end
                end

                StDelay: begin
                    if (dly_q == '0) begin
                        state <= StIntegrate;
                    end else if (adc_valid) begin
                        if (last_dly) begin
                            cnt_q <= '0;
                            state <= StIntegrate;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end

                StIntegrate: begin
                    if (win_q == '0) begin
                        // Empty window: accumulators are still cleared.
                        i_val    <= acc_i_q;
                        q_val    <= acc_q_q;
                        overflow <= ovf_q;
                        iq_valid <= 1'b1;
                        state    <= StDone;
                    end else if (adc_valid) begin
                        acc_i_q <= acc_i_d;
                        acc_q_q <= acc_q_d;
                        ovf_q   <= ovf_d;
                        phase_q <= phase_q + pinc_q;
                        if (last_win) begin
                            cnt_q    <= '0;
                            i_val    <= acc_i_d;
                            q_val    <= acc_q_d;
                            overflow <= ovf_d;
                            iq_valid <= 1'b1;
                            state    <= StDone;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end

                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_demod.sv
// Scoreboard bench for iq_demod: the stimulus side computes each measurement's
// expected I/Q/overflow from a plain-arithmetic model and queues it; a monitor
// pops and compares on every iq_valid strobe.
module tb_iq_demod;

    localparam longint AccMax = 64'sd2147483647;
    localparam longint AccMin = -64'sd2147483648;

    typedef struct {
        int i;
        int q;
        bit ovf;
    } exp_t;

    logic               clk100 = 1'b0;
    logic               rst;
    logic               trigger;
    logic signed [13:0] adc_data;
    logic               adc_valid;
    logic        [15:0] delay_len;
    logic        [15:0] window_len;
    logic        [3:0]  pinc;
    logic signed [31:0] i_val;
    logic signed [31:0] q_val;
    logic               iq_valid;
    logic               busy;
    logic               overflow;

    int   errors = 0;
    int   checks = 0;
    int   cos_t [16];
    int   sin_t [16];
    exp_t exp_q [$];

    always #5 clk100 = ~clk100;

    iq_demod dut (
        .clk100     (clk100),
        .rst        (rst),
        .trigger    (trigger),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .delay_len  (delay_len),
        .window_len (window_len),
        .pinc       (pinc),
        .i_val      (i_val),
        .q_val      (q_val),
        .iq_valid   (iq_valid),
        .busy       (busy),
        .overflow   (overflow)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // 32-bit signed accumulate with overflow detection, clamped or wrapped.
    function automatic longint acc_add(input longint a, input longint p, output bit o);
        longint      s;
        logic [31:0] t;
        s = a + p;
        o = (s > AccMax) || (s < AccMin);
`ifdef IQ_DEMOD_SATURATE_EN
        if (s > AccMax) s = AccMax;
        else if (s < AccMin) s = AccMin;
`else
        t = s[31:0];
        s = longint'($signed(t));
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    // mode: 0 = valid every cycle, 1 = alternate, 2 = random
    task automatic run_meas(input int dly, input int win, input int pc, input int mode,
                            input bit fixed, input int fval, input bit extra_trig);
        longint ai = 0;
        longint aq = 0;
        bit     ov = 0;
        bit     o1, o2;
        int     skipped = 0;
        int     taken = 0;
        bit     done = 0;
        bit     v;
        int     d;
        int     ph;
        int     c = 0;
        exp_t   e;

        check("busy_idle_before_trigger", busy, 0);
        delay_len  = dly[15:0];
        window_len = win[15:0];
        pinc       = pc[3:0];
        trigger    = 1'b1;
        adc_valid  = 1'b0;
        tick();
        trigger = 1'b0;
        check("busy_after_trigger", busy, 1);
        // Scramble config inputs: the DUT must be using its latched copies.
        delay_len  = 16'($urandom);
        window_len = 16'($urandom);
        pinc       = 4'($urandom);
        if (dly == 0 && win == 0) begin
            e.i = 0; e.q = 0; e.ovf = 0;
            exp_q.push_back(e);
            done = 1;
        end
        tick();
        while (!done && c < 200000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            d = fixed ? fval : int'($urandom_range(0, 16383)) - 8192;
            adc_valid = v;
            adc_data  = d[13:0];
            trigger   = extra_trig && (c == 3);
            if (v) begin
                if (skipped < dly) begin
                    skipped++;
                end else if (taken < win) begin
                    ph = (taken * pc) % 16;
                    ai = acc_add(ai, longint'(d) * cos_t[ph], o1);
                    aq = acc_add(aq, longint'(d) * sin_t[ph], o2);
                    ov = ov | o1 | o2;
                    taken++;
                end
            end
            if (skipped == dly && taken == win) begin
                e.i = int'(ai); e.q = int'(aq); e.ovf = ov;
                exp_q.push_back(e);
                done = 1;
            end
            tick();
            c++;
        end
        if (!done) check("stimulus_budget", c, -1);
        // Trigger and samples while finishing must be ignored.
        for (int k = 0; k < ((win == 0) ? 2 : 1); k++) begin
            trigger   = 1'b1;
            adc_valid = 1'b1;
            adc_data  = 14'($urandom);
            tick();
        end
        trigger   = 1'b0;
        adc_valid = 1'b0;
    endtask

    // Abort a measurement with reset after n valid samples (trigger held too).
    task automatic reset_mid(input int dly, input int win, input int n, input string tag);
        delay_len  = dly[15:0];
        window_len = win[15:0];
        pinc       = 4'd1;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 0; k < n; k++) begin
            adc_valid = 1'b1;
            adc_data  = 14'($urandom);
            tick();
        end
        rst     = 1'b1;
        trigger = 1'b1;
        tick();
        rst       = 1'b0;
        trigger   = 1'b0;
        adc_valid = 1'b0;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_i_val"}, i_val, 0);
        check({tag, "_q_val"}, q_val, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_iq_valid"}, iq_valid, 0);
        repeat (3) tick();
        check({tag, "_busy_stays_low"}, busy, 0);
    endtask

    // Monitor: every iq_valid must match the oldest queued expectation.
    always @(negedge clk100) begin
        if (!rst && iq_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_iq_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("i_val", i_val, e.i);
                check("q_val", q_val, e.q);
                check("overflow", overflow, e.ovf);
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            cos_t[k] = int'(2047.0 * $cos(2.0 * 3.141592653589793 * k / 16.0));
            sin_t[k] = int'(2047.0 * $sin(2.0 * 3.141592653589793 * k / 16.0));
        end
        rst        = 1'b1;
        trigger    = 1'b0;
        adc_valid  = 1'b0;
        adc_data   = '0;
        delay_len  = '0;
        window_len = '0;
        pinc       = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_iq_valid", iq_valid, 0);
        check("reset_i_val", i_val, 0);
        check("reset_q_val", q_val, 0);
        check("reset_overflow", overflow, 0);
        tick();

        // Directed cases.
        run_meas(2, 4, 0, 0, 1, 100, 0);
        run_meas(0, 4, 4, 0, 1, 100, 0);
        run_meas(3, 0, 0, 0, 0, 0, 0);
        run_meas(0, 0, 3, 0, 0, 0, 0);
        run_meas(1, 12, 3, 1, 0, 0, 1);
        run_meas(1, 12, 3, 0, 0, 0, 0);

        // Reset aborts mid-DELAY and mid-INTEGRATE, after a nonzero result.
        reset_mid(30, 5, 4, "rst_delay");
        run_meas(0, 3, 1, 0, 1, 1234, 0);
        reset_mid(2, 30, 8, "rst_integrate");

        // Randomized measurements.
        for (int r = 0; r < 24; r++) begin
            run_meas(int'($urandom_range(0, 5)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                     1'b0, 0, 1'b1);
        end

        // Long negative full-scale window forces accumulator overflow.
        run_meas(0, 65535, 0, 0, 1, -8192, 0);

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iq_demod.md
IQ_DEMOD -- requirements
Module: iq_demod

Interface
REQ-001 SHALL have parameter ADC_W, default 14, signed ADC sample width.
REQ-002 SHALL have parameter COEF_W, default 12, signed LUT coefficient width.
REQ-003 SHALL have ports clk100 (input, 1, sole clock) and rst (input, 1); reset is synchronous and active-high.
REQ-004 SHALL have port trigger (input, 1): a pulse that starts one readout measurement.
REQ-005 SHALL have port adc_data (input, ADC_W, signed sample) and port adc_valid (input, 1, sample qualifier).
REQ-006 SHALL have port delay_len (input, 16): samples to skip after the trigger.
REQ-007 SHALL have port window_len (input, 16): samples to integrate.
REQ-008 SHALL have port pinc (input, 4): phase increment per sample, modulo 16.
REQ-009 SHALL have ports i_val and q_val (output, 32, signed integrated I/Q, held until the next result).
REQ-010 SHALL have port iq_valid (output, 1): a 1-cycle strobe when i_val/q_val update.
REQ-011 SHALL have ports busy (output, 1, high when state is not IDLE) and overflow (output, 1, accumulator overflow in the last result).

Function
REQ-012 SHALL implement states IDLE, DELAY, INTEGRATE, DONE.
REQ-013 IDLE: trigger=1 SHALL latch delay_len, window_len and pinc, clear the accumulators, phase and overflow, and go to DELAY.
REQ-014 DELAY SHALL count adc_valid samples and go to INTEGRATE after delay_len samples.
- delay_len=0: INTEGRATE the next cycle.
REQ-015 INTEGRATE, each adc_valid cycle:
- acc_i += adc_data*COS[phase]; acc_q += adc_data*SIN[phase].
- phase <= phase + pinc_latched (mod 16).
REQ-016 Products SHALL be (ADC_W+COEF_W)-bit signed, sign-extended to 32 bits before accumulation.
REQ-017 After window_len samples in INTEGRATE, the block SHALL go to DONE.
- window_len=0: go to DONE immediately with a zero result.
REQ-018 DONE (1 cycle): i_val/q_val <= accumulators, iq_valid=1, then IDLE.
- Latency: last integrated sample to iq_valid = 1 cycle.
REQ-019 trigger while busy=1 SHALL be ignored; it is neither queued nor restarts the measurement.
REQ-020 adc_valid=0 cycles SHALL stall the counters and phase without other effect.
REQ-021 A 32-bit signed overflow on either accumulator SHALL set overflow (sticky until the next trigger); overflow updates with i_val.
REQ-022 trigger in the DONE cycle SHALL be ignored; trigger in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-023 rst SHALL force IDLE and clear the accumulators, phase, counters, i_val, q_val, iq_valid, busy and overflow to 0.
REQ-024 rst mid-measurement SHALL abort the measurement with no iq_valid; rst SHALL dominate trigger in the same cycle.

Configuration
REQ-025 With IQ_DEMOD_SATURATE_EN defined, accumulators SHALL clamp at +2^31-1 / -2^31 on overflow, and overflow is still flagged.
REQ-026 Without IQ_DEMOD_SATURATE_EN, accumulators SHALL wrap two's-complement, and overflow is flagged.

Structure
REQ-027 A shared package SHALL hold the state encoding, ADC_W/COEF_W defaults and the LUT depth constant (16).
REQ-028 Sub-module iq_demod_lut SHALL hold the combinational 16-entry COS/SIN table.
- Entries = round(2047*cos/sin(2*pi*k/16)).
- COS[0]=2047, SIN[0]=0, SIN[4]=2047.

Verification
REQ-029 pinc=0, adc_data=100 constant, delay_len=2, window_len=4 -> iq_valid once; i_val=818800, q_val=0, overflow=0.
REQ-030 pinc=4, adc_data=100, delay_len=0, window_len=4 -> phases 0,4,8,12; i_val=0, q_val=0.
REQ-031 window_len=0, delay_len=3 -> iq_valid after 3 samples; i_val=q_val=0.
REQ-032 Second trigger mid-INTEGRATE, and adc_valid toggled 50% -> one iq_valid; result identical to gap-free run.
REQ-033 adc_data=-8192, pinc=0, window_len=65535 -> overflow=1; i_val=-2147483648 with IQ_DEMOD_SATURATE_EN, wrapped value without it.
REQ-034 rst asserted during DELAY and during INTEGRATE -> no iq_valid, busy=0 next cycle, all outputs 0.
